// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the tapped-delay-line hit sequencer.
package tdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int unsigned DROP_W = 8;

   function automatic int unsigned ntaps_of(input int unsigned ncarry4);
      return 4 * ncarry4;
   endfunction

   // Fine code spans 0..NTAPS inclusive, hence the +1.
   function automatic int unsigned fine_w_of(input int unsigned ntaps);
      return $clog2(ntaps + 1);
   endfunction

endpackage

// File: rtl/tdc_therm_decoder.sv
// Thermometer-to-binary decoder for the sampled tap word.
// TDC_BUBBLE_FIX_EN: count only the leading run of ones from tap 0; otherwise popcount.
module tdc_therm_decoder
   import tdc_pkg::*;
#(
   parameter  int unsigned NTAPS  = 8,
   localparam int unsigned FINE_W = fine_w_of(NTAPS)
) (
   input  logic [NTAPS-1:0]  taps,
   output logic [FINE_W-1:0] fine_c
);

`ifdef TDC_BUBBLE_FIX_EN
   logic run;

   // Ones after the first zero are bubbles and are ignored.
   always_comb begin
      fine_c = '0;
      run    = 1'b1;
      for (int i = 0; i < int'(NTAPS); i++) begin
         run    = run & taps[i];
         fine_c = fine_c + FINE_W'(run);
      end
   end
`else
   always_comb begin
      fine_c = '0;
      for (int i = 0; i < int'(NTAPS); i++) begin
         fine_c = fine_c + FINE_W'(taps[i]);
      end
   end
`endif

endmodule

// File: rtl/tdc_hit_sequencer.sv
// Arms the carry chain, detects a hit, and emits fine/coarse timestamps on valid/ready.
// Fine decode style is selected inside tdc_therm_decoder by TDC_BUBBLE_FIX_EN.
module tdc_hit_sequencer
   import tdc_pkg::*;
#(
   parameter  int unsigned NCARRY4     = 2,
   parameter  int unsigned COARSE_W    = 16,
   parameter  int unsigned DEAD_CYCLES = 4,
   localparam int unsigned NTAPS       = ntaps_of(NCARRY4),
   localparam int unsigned FINE_W      = fine_w_of(NTAPS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                cal_mode,
   input  logic                hit_in,
   input  logic                cal_hit,
   output logic                dl_ci,
   input  logic [NTAPS-1:0]    tap_in,
   output logic [FINE_W-1:0]   ts_fine,
   output logic [COARSE_W-1:0] ts_coarse,
   output logic                ts_cal,
   output logic                ts_valid,
   input  logic                ts_ready,
   output logic [DROP_W-1:0]   drop_cnt,
   output logic                busy
);

   localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

   state_t                state_q;
   state_t                state_next;
   logic                  capture;
   logic                  arm_q;
   logic                  cal_q;
   logic [COARSE_W-1:0]   coarse_q;
   logic [DEAD_W-1:0]     dead_q;
   logic                  dead_done;
   logic                  line_clear;
   logic [FINE_W-1:0]     fine_c;

   tdc_therm_decoder #(.NTAPS(NTAPS)) u_decoder (
      .taps   (tap_in),
      .fine_c (fine_c)
   );

   assign line_clear = (tap_in == '0);
   assign dead_done  = (dead_q >= DEAD_LAST);

   // Hit gate into the carry chain; only the arm/select terms are registered.
   assign dl_ci = arm_q & (cal_q ? cal_hit : hit_in);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_next;
   end

   // Next-state logic; a capture outranks a concurrent disable.
   always_comb begin
      state_next = state_q;
      capture    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_next = line_clear ? ST_ARMED : ST_DRAIN;
         end
         ST_ARMED: begin
            if (tap_in[0]) begin
               capture    = 1'b1;
               state_next = ST_DRAIN;
            end else if (!enable) begin
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (dead_done && line_clear) state_next = enable ? ST_ARMED : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   // Arm, calibration select, coarse time, dead-time count and the one-entry output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         arm_q     <= 1'b0;
         cal_q     <= 1'b0;
         coarse_q  <= '0;
         dead_q    <= '0;
         ts_valid  <= 1'b0;
         ts_fine   <= '0;
         ts_coarse <= '0;
         ts_cal    <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         arm_q    <= (state_next == ST_ARMED);
         coarse_q <= coarse_q + COARSE_W'(1);

         if (state_q == ST_IDLE) cal_q <= cal_mode;

         if (state_q == ST_DRAIN && state_next == ST_DRAIN) begin
            if (!dead_done) dead_q <= dead_q + DEAD_W'(1);
         end else begin
            dead_q <= '0;
         end

         if (capture && (!ts_valid || ts_ready)) begin
            ts_valid  <= 1'b1;
            ts_fine   <= fine_c;
            ts_coarse <= coarse_q;
            ts_cal    <= cal_q;
         end else if (capture) begin
            if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
         end else if (ts_valid && ts_ready) begin
            ts_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/tdc_hit_sequencer.md
Name: tdc_hit_sequencer

Overview:
Sequencer for the CARRY4 tapped delay line: arms and disarms the line's carry input, detects a hit in the sampled tap word, and decodes the thermometer code into a fine time. The fine time is paired with a free-running coarse counter and presented as a timestamp on a valid/ready interface. After each hit the sequencer enforces a drain (dead-time) phase. It sits between the delay line plus its tap sampling flops and the readout FIFO.

Parameters:
NCARRY4, 2, number of chained CARRY4 cells; NTAPS = 4*NCARRY4
COARSE_W, 16, coarse counter width
DEAD_CYCLES, 4, minimum cycles the line is held disarmed after a hit (>=1)

Ports:
clk  in  1  system clock; tap sampling flops are on the same clock
rst  in  1  synchronous, active-high reset
enable  in  1  run request
cal_mode  in  1  1: route cal_hit into line, 0: route hit_in
hit_in  in  1  asynchronous physics hit
cal_hit  in  1  asynchronous calibration source (uncorrelated oscillator)
dl_ci  out  1  drives delay line CI
tap_in  in  NTAPS  registered tap word; bit 0 is nearest CI
ts_fine  out  FINE_W  decoded fine code, 0..NTAPS; FINE_W = clog2(NTAPS+1)
ts_coarse  out  COARSE_W  coarse count at detection
ts_cal  out  1  timestamp was taken in cal_mode
ts_valid  out  1  timestamp valid
ts_ready  in  1  consumer accepts
drop_cnt  out  8  saturating count of hits lost to backpressure
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; coarse counter 0; arm_q 0.
- dl_ci = arm_q & (cal_mode ? cal_hit : hit_in). The gate is combinational, and arm_q is registered. cal_mode is sampled only in IDLE, into cal_q, which drives the mux.
- Coarse counter: increments every cycle after reset; wraps from 2^COARSE_W-1 to 0 with no flag.
- IDLE: arm_q=0. enable=1 -> ARMED, but only if tap_in==0; otherwise go to DRAIN.
- ARMED: arm_q=1.
  - enable=0 -> IDLE.
  - tap_in[0]==1 -> capture fine=decode(tap_in), coarse=current counter, cal=cal_q; go to DRAIN.
  - If enable=0 and tap_in[0]=1 in the same cycle, the capture wins and the FSM goes to DRAIN.
- DRAIN: arm_q=0. Count DEAD_CYCLES cycles, then wait until tap_in==0.
  - If enable=1, go to ARMED; otherwise go to IDLE.
  - A stuck-high line holds the FSM in DRAIN indefinitely.
- Output register (one entry):
  - A capture at cycle N gives ts_valid=1 at N+1.
  - Transfer occurs when ts_valid & ts_ready.
  - A capture while ts_valid=1 and no transfer that cycle: the new capture is dropped, drop_cnt increments (saturating at 255), and the held timestamp is unchanged.
  - If a transfer and a capture happen in the same cycle, the new capture loads.
  - ts_valid stays asserted and the held timestamp is stable until transfer, independent of enable.
- decode, default: popcount(tap_in). An all-ones tap word gives NTAPS (saturated: the hit arrived earlier than the full line delay).
- rst in any state: IDLE next cycle, arm_q=0, ts_valid=0, pending timestamp discarded, drop_cnt=0, coarse counter=0.

Optional Feature:
- Macro TDC_BUBBLE_FIX_EN.
- Defined: decode = length of the run of consecutive ones starting at tap_in[0], which removes bubbles beyond the first zero.
- Undefined: decode = popcount.
- Example: tap_in=8'b0001_0111 gives 3 when defined and 4 when undefined.

Decomposition:
- Package tdc_pkg: state encoding (IDLE, ARMED, DRAIN), NTAPS and FINE_W derivation functions, and the drop counter width constant.
- One sub-module, tdc_therm_decoder: purely combinational, NTAPS in, FINE_W out. It holds the TDC_BUBBLE_FIX_EN selection, so the sequencer stays decode-agnostic.

Test Plan:
- Reset, enable=1, tap_in=0 -> ARMED after 1 cycle; dl_ci follows hit_in. Inject tap_in=8'b0000_0111 at coarse=0x0010 -> next cycle ts_valid=1, ts_fine=3, ts_coarse=0x0010, ts_cal=0; dl_ci forced 0.
- After a capture, hold tap_in nonzero for 10 cycles -> FSM stays in DRAIN for all 10 cycles. Clear tap_in -> ARMED after max(DEAD_CYCLES, clear) + 1 cycles.
- ts_ready=0 with three captures -> first timestamp held, drop_cnt=2. Then ts_ready=1 in the same cycle as a capture -> new timestamp loaded, ts_valid stays 1.
- tap_in=8'hFF -> ts_fine=8. tap_in=8'b0001_0111 -> ts_fine=3 with TDC_BUBBLE_FIX_EN, 4 without.
- cal_mode=1 in IDLE, then enable -> dl_ci follows cal_hit and ts_cal=1. Toggle cal_mode while ARMED -> no effect until the next pass through IDLE.
- Assert rst while ts_valid=1 and the FSM is in DRAIN -> next cycle all outputs 0 and the coarse counter restarts from 0. Separately, a coarse wrap at 0xFFFF -> 0x0000 is captured correctly.
